// File: rtl/stepper_ramp_gen_pkg.sv
// Shared state encoding and default widths for the stepper step/dir ramp generator.
package stepper_ramp_gen_pkg;

    localparam int CNT_W_DEF     = 32;
    localparam int DIV_W_DEF     = 16;
    localparam int DIR_SETUP_DEF = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_ACCEL  = 3'd2,
        ST_CRUISE = 3'd3,
        ST_DECEL  = 3'd4
    } state_e;

endpackage

// File: rtl/stepper_ramp_gen_step_phase_timer.sv
// Half-period down-counter: a load of N makes expired high during the N-th cycle after the load,
// so the owner acts on the clock edge exactly N cycles after loading.
module stepper_ramp_gen_step_phase_timer
    import stepper_ramp_gen_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [DIV_W-1:0] load_val,
    output logic             expired
);

    logic [DIV_W-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (load) begin
            // A zero load behaves like a one-cycle phase rather than wrapping.
            cnt_reg <= (load_val == '0) ? '0 : load_val - DIV_W'(1);
        end else if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - DIV_W'(1);
        end
    end

    assign expired = (cnt_reg == '0);

endmodule

// File: rtl/stepper_ramp_gen.sv
// Step/dir generator for one stepper axis with a linear accel/cruise/decel profile,
// graceful abort and a start/busy/done handshake.
module stepper_ramp_gen
    import stepper_ramp_gen_pkg::*;
#(
    parameter int CNT_W     = CNT_W_DEF,
    parameter int DIV_W     = DIV_W_DEF,
    parameter int DIR_SETUP = DIR_SETUP_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             dir_in,
    input  logic [CNT_W-1:0] step_count,
    input  logic [DIV_W-1:0] cruise_half,
    input  logic [DIV_W-1:0] start_half,
    input  logic [DIV_W-1:0] ramp_delta,
    output logic             step,
    output logic             dir,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [CNT_W-1:0] steps_done
);

    state_e           state_reg, state_next;
    logic             step_reg, step_next;
    logic             dir_reg, dir_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;
    logic             aborted_reg, aborted_next;
    logic             abort_pend_reg, abort_pend_next;
    logic [CNT_W-1:0] steps_done_reg, steps_done_next;
    logic [CNT_W-1:0] accel_steps_reg, accel_steps_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [DIV_W-1:0] cur_half_reg, cur_half_next;
    logic [DIV_W-1:0] start_half_reg, start_half_next;
    logic [DIV_W-1:0] cruise_half_reg, cruise_half_next;
    logic [DIV_W-1:0] delta_reg, delta_next;

    logic             timer_load;
    logic [DIV_W-1:0] timer_val;
    logic             timer_expired;

    logic [DIV_W-1:0] start_nz, cruise_nz;
    logic [DIV_W:0]   dn_wide, up_wide;
    logic [DIV_W-1:0] ramp_dn, ramp_up, half_new;
    logic [CNT_W-1:0] remaining;
    logic             ramp_en, last_step;

    stepper_ramp_gen_step_phase_timer #(
        .DIV_W(DIV_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timer_load),
        .load_val (timer_val),
        .expired  (timer_expired)
    );

    assign start_nz  = (start_half == '0) ? DIV_W'(1) : start_half;
    assign cruise_nz = (cruise_half == '0) ? DIV_W'(1) : cruise_half;

    // Ramp arithmetic is done one bit wider so the saturation is exact.
    assign dn_wide = {1'b0, cur_half_reg} - {1'b0, delta_reg};
    assign up_wide = {1'b0, cur_half_reg} + {1'b0, delta_reg};
    assign ramp_dn = (dn_wide[DIV_W] || (dn_wide[DIV_W-1:0] < cruise_half_reg))
                     ? cruise_half_reg : dn_wide[DIV_W-1:0];
    assign ramp_up = (up_wide > {1'b0, start_half_reg}) ? start_half_reg : up_wide[DIV_W-1:0];

    assign ramp_en   = (delta_reg != '0) && (start_half_reg > cruise_half_reg);
    assign remaining = count_reg - steps_done_reg;
    assign last_step = (steps_done_reg == count_reg);

    always_comb begin
        state_next       = state_reg;
        step_next        = step_reg;
        dir_next         = dir_reg;
        busy_next        = busy_reg;
        done_next        = 1'b0;
        aborted_next     = aborted_reg;
        abort_pend_next  = abort_pend_reg;
        steps_done_next  = steps_done_reg;
        accel_steps_next = accel_steps_reg;
        count_next       = count_reg;
        cur_half_next    = cur_half_reg;
        start_half_next  = start_half_reg;
        cruise_half_next = cruise_half_reg;
        delta_next       = delta_reg;
        timer_load       = 1'b0;
        timer_val        = cur_half_reg;
        half_new         = cur_half_reg;

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    count_next       = step_count;
                    start_half_next  = start_nz;
                    cruise_half_next = cruise_nz;
                    delta_next       = ramp_delta;
                    cur_half_next    = (start_nz > cruise_nz) ? start_nz : cruise_nz;
                    steps_done_next  = '0;
                    accel_steps_next = '0;
                    aborted_next     = 1'b0;
                    abort_pend_next  = 1'b0;
                    if (step_count == '0) begin
                        done_next = 1'b1;
                    end else begin
                        state_next = ST_SETUP;
                        busy_next  = 1'b1;
                        dir_next   = dir_in;
                        timer_load = 1'b1;
                        timer_val  = DIV_W'(DIR_SETUP);
                    end
                end
            end

            ST_SETUP: begin
                if (abort) begin
                    state_next   = ST_IDLE;
                    busy_next    = 1'b0;
                    done_next    = 1'b1;
                    aborted_next = 1'b1;
                end else if (timer_expired) begin
                    step_next       = 1'b1;
                    steps_done_next = steps_done_reg + CNT_W'(1);
                    timer_load      = 1'b1;
                    state_next      = ramp_en ? ST_ACCEL : ST_CRUISE;
                end
            end

            ST_ACCEL, ST_CRUISE, ST_DECEL: begin
                if (abort) begin
                    abort_pend_next = 1'b1;
                end
                if (timer_expired) begin
                    if (step_reg) begin
                        step_next  = 1'b0;
                        timer_load = 1'b1;
                    end else if (last_step) begin
                        state_next = ST_IDLE;
                        busy_next  = 1'b0;
                        done_next  = 1'b1;
                    end else if (abort_pend_reg || abort) begin
                        state_next   = ST_IDLE;
                        busy_next    = 1'b0;
                        done_next    = 1'b1;
                        aborted_next = 1'b1;
                    end else begin
                        case (state_reg)
                            ST_ACCEL: begin
                                // Triangle peak: the step just taken is repeated once going down,
                                // which keeps even-length triangles symmetric.
                                if (remaining <= accel_steps_reg + CNT_W'(1)) begin
                                    state_next = ST_DECEL;
                                end else begin
                                    half_new         = ramp_dn;
                                    accel_steps_next = accel_steps_reg + CNT_W'(1);
                                    if (ramp_dn == cruise_half_reg) begin
                                        state_next = ST_CRUISE;
                                    end
                                end
                            end
                            ST_CRUISE: begin
                                if (remaining <= accel_steps_reg) begin
                                    state_next = ST_DECEL;
                                    half_new   = ramp_up;
                                end
                            end
                            default: begin
                                half_new = ramp_up;
                            end
                        endcase
                        cur_half_next   = half_new;
                        step_next       = 1'b1;
                        steps_done_next = steps_done_reg + CNT_W'(1);
                        timer_load      = 1'b1;
                        timer_val       = half_new;
                    end
                end
            end

            default: begin
                state_next = ST_IDLE;
                step_next  = 1'b0;
                busy_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_IDLE;
            step_reg        <= 1'b0;
            dir_reg         <= 1'b0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
            aborted_reg     <= 1'b0;
            abort_pend_reg  <= 1'b0;
            steps_done_reg  <= '0;
            accel_steps_reg <= '0;
            count_reg       <= '0;
            cur_half_reg    <= '0;
            start_half_reg  <= '0;
            cruise_half_reg <= '0;
            delta_reg       <= '0;
        end else begin
            state_reg       <= state_next;
            step_reg        <= step_next;
            dir_reg         <= dir_next;
            busy_reg        <= busy_next;
            done_reg        <= done_next;
            aborted_reg     <= aborted_next;
            abort_pend_reg  <= abort_pend_next;
            steps_done_reg  <= steps_done_next;
            accel_steps_reg <= accel_steps_next;
            count_reg       <= count_next;
            cur_half_reg    <= cur_half_next;
            start_half_reg  <= start_half_next;
            cruise_half_reg <= cruise_half_next;
            delta_reg       <= delta_next;
        end
    end

    assign step       = step_reg;
    assign dir        = dir_reg;
    assign busy       = busy_reg;
    assign done       = done_reg;
    assign aborted    = aborted_reg;
    assign steps_done = steps_done_reg;

endmodule

// File: tb/tb_stepper_ramp_gen.sv
// Scoreboard bench for stepper_ramp_gen: stimulus queues expected setup/pulse/done events,
// a negedge monitor measures the pins and pops/compares.
module tb_stepper_ramp_gen;

    localparam int CNT_W     = 32;
    localparam int DIV_W     = 16;
    localparam int DIR_SETUP = 4;

    localparam int K_SETUP = 0;
    localparam int K_PULSE = 1;
    localparam int K_DONE  = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic             dir_in = 1'b0;
    logic [CNT_W-1:0] step_count = '0;
    logic [DIV_W-1:0] cruise_half = '0;
    logic [DIV_W-1:0] start_half = '0;
    logic [DIV_W-1:0] ramp_delta = '0;
    logic             step, dir, busy, done, aborted;
    logic [CNT_W-1:0] steps_done;

    int tests_run = 0;
    int fails = 0;

    typedef struct {
        int kind;
        int a;
        int b;
        int c;
    } exp_t;

    exp_t exp_q[$];

    stepper_ramp_gen #(
        .CNT_W(CNT_W),
        .DIV_W(DIV_W),
        .DIR_SETUP(DIR_SETUP)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .dir_in      (dir_in),
        .step_count  (step_count),
        .cruise_half (cruise_half),
        .start_half  (start_half),
        .ramp_delta  (ramp_delta),
        .step        (step),
        .dir         (dir),
        .busy        (busy),
        .done        (done),
        .aborted     (aborted),
        .steps_done  (steps_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint expv);
        tests_run++;
        if (act != expv) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    task automatic push(input int k, input int a, input int b, input int c);
        exp_t e;
        e.kind = k; e.a = a; e.b = b; e.c = c;
        exp_q.push_back(e);
    endtask

    task automatic push_pulses(input int h, input int n);
        for (int i = 0; i < n; i++) push(K_PULSE, h, h, 0);
    endtask

    task automatic sb_pop(input int k, input int a, input int b, input int c);
        exp_t e;
        if (exp_q.size() == 0) begin
            tests_run++;
            fails++;
            $display("FAIL sb_unexpected: got event kind %0d (%0d,%0d,%0d), expected no event", k, a, b, c);
        end else begin
            e = exp_q.pop_front();
            check("sb_kind", k, e.kind);
            if (k == e.kind) begin
                case (k)
                    K_SETUP: check("setup_cycles", a, e.a);
                    K_PULSE: begin
                        check("pulse_high", a, e.a);
                        check("pulse_low", b, e.b);
                    end
                    default: begin
                        check("done_steps", a, e.a);
                        check("done_aborted", b, e.b);
                        check("done_dir", c, e.c);
                    end
                endcase
            end
        end
    endtask

    // Monitor: measures pulse widths and setup delay, reports events to the scoreboard.
    int hi_cnt = 0, lo_cnt = 0, setup_cnt = 0;
    bit have_pulse = 0, setup_arm = 0, prev_step = 0, prev_busy = 0, prev_done = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            have_pulse = 0; setup_arm = 0; prev_step = 0; prev_busy = 0; prev_done = 0;
        end else begin
            if (busy && !prev_busy) begin
                setup_arm = 1;
                setup_cnt = 0;
            end
            if (done) begin
                if (have_pulse) sb_pop(K_PULSE, hi_cnt, lo_cnt, 0);
                have_pulse = 0;
                setup_arm  = 0;
                check("done_width", int'(prev_done), 0);
                check("busy_at_done", int'(busy), 0);
                sb_pop(K_DONE, int'(steps_done), int'(aborted), int'(dir));
                $display("[TB] move end: steps_done=%0d aborted=%0d dir=%0d", steps_done, aborted, dir);
            end else if (step) begin
                if (!prev_step) begin
                    if (setup_arm) begin
                        sb_pop(K_SETUP, setup_cnt, 0, 0);
                        setup_arm = 0;
                    end
                    if (have_pulse) sb_pop(K_PULSE, hi_cnt, lo_cnt, 0);
                    hi_cnt = 1;
                    lo_cnt = 0;
                    have_pulse = 1;
                end else begin
                    hi_cnt++;
                end
            end else begin
                if (have_pulse) lo_cnt++;
                if (setup_arm) setup_cnt++;
            end
            prev_step = step;
            prev_busy = busy;
            prev_done = done;
        end
    end

    task automatic do_start(input int cnt, input int sh, input int ch, input int dl, input bit d);
        @(negedge clk);
        step_count  = CNT_W'(cnt);
        start_half  = DIV_W'(sh);
        cruise_half = DIV_W'(ch);
        ramp_delta  = DIV_W'(dl);
        dir_in      = d;
        start       = 1'b1;
        @(negedge clk);
        start       = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        bit seen = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                break;
            end
        end
        if (!seen) begin
            tests_run++;
            fails++;
            $display("FAIL %s_timeout: got no done, expected done within %0d cycles", name, budget);
        end
        @(negedge clk);
    endtask

    task automatic wait_step(input int n, input int budget, input string name);
        bit seen = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (steps_done == CNT_W'(n) && step) begin
                seen = 1;
                break;
            end
        end
        if (!seen) begin
            tests_run++;
            fails++;
            $display("FAIL %s_timeout: got steps_done=%0d, expected %0d within %0d cycles", name, steps_done, n, budget);
        end
    endtask

    task automatic push_ramp20(input int d);
        push(K_SETUP, DIR_SETUP, 0, 0);
        push_pulses(10, 1); push_pulses(8, 1); push_pulses(6, 1);
        push_pulses(4, 14);
        push_pulses(6, 1); push_pulses(8, 1); push_pulses(10, 1);
        push(K_DONE, 20, 0, d);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_step"}, int'(step), 0);
        check({tag, "_dir"}, int'(dir), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_aborted"}, int'(aborted), 0);
        check({tag, "_steps_done"}, longint'(steps_done), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got sim time %0t, expected finish earlier", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        // Asynchronous reset applied mid-cycle.
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_all_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Constant rate, 5 steps of 3/3; a second start while busy must be ignored.
        push(K_SETUP, DIR_SETUP, 0, 0);
        push_pulses(3, 5);
        push(K_DONE, 5, 0, 1);
        do_start(5, 3, 3, 0, 1'b1);
        check("busy_after_start", int'(busy), 1);
        check("dir_after_start", int'(dir), 1);
        repeat (10) @(negedge clk);
        step_count = CNT_W'(9);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(300, "const5");

        // Zero count: done the cycle after start, never busy.
        push(K_DONE, 0, 0, 1);
        do_start(0, 3, 3, 0, 1'b1);
        check("zero_done_next_cycle", int'(done), 1);
        check("zero_busy", int'(busy), 0);
        @(negedge clk);
        check("zero_done_one_cycle", int'(done), 0);
        check("zero_busy_after", int'(busy), 0);
        check("zero_step", int'(step), 0);
        repeat (2) @(negedge clk);

        // Trapezoid ramp 10,8,6,4..4,6,8,10.
        push_ramp20(0);
        do_start(20, 10, 4, 2, 1'b0);
        wait_done(1000, "trapezoid");

        // Triangle 10,8,8,10.
        push(K_SETUP, DIR_SETUP, 0, 0);
        push_pulses(10, 1); push_pulses(8, 2); push_pulses(10, 1);
        push(K_DONE, 4, 0, 1);
        do_start(4, 10, 2, 2, 1'b1);
        wait_done(400, "triangle");

        // Abort in SETUP: immediate end, no STEP.
        push(K_DONE, 0, 1, 0);
        do_start(7, 2, 2, 0, 1'b0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_setup_done", int'(done), 1);
        repeat (2) @(negedge clk);

        // Abort during the high phase of pulse 5: that pulse completes fully.
        push(K_SETUP, DIR_SETUP, 0, 0);
        push_pulses(3, 5);
        push(K_DONE, 5, 1, 1);
        do_start(100, 3, 3, 0, 1'b1);
        wait_step(5, 200, "abort_wait");
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        wait_done(200, "abort_run");

        // Next start clears aborted.
        push(K_SETUP, DIR_SETUP, 0, 0);
        push_pulses(2, 2);
        push(K_DONE, 2, 0, 0);
        do_start(2, 2, 2, 0, 1'b0);
        check("aborted_cleared", int'(aborted), 0);
        wait_done(100, "after_abort");

        // Reset mid-DECEL, then a full fresh move.
        push(K_SETUP, DIR_SETUP, 0, 0);
        push_pulses(10, 1); push_pulses(8, 1); push_pulses(6, 1);
        push_pulses(4, 14);
        do_start(20, 10, 4, 2, 1'b1);
        wait_step(18, 1000, "decel_wait");
        #1 rst_n = 1'b0;
        #1 check_all_zero("decel_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        push_ramp20(1);
        do_start(20, 10, 4, 2, 1'b1);
        wait_done(1000, "post_reset");

        repeat (3) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
